seven_seg_scan_ctrl: RTL and testbench

//  Parametrised multiplexed seven-segment display controller: N-digit scan.

---
 rtl/seven_seg_pkg.sv | 20 ++
 rtl/seven_seg_decoder.sv | 31 +++
 rtl/seven_seg_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller.
package seven_seg_pkg;

    // Register map seen on ADR_I
    typedef enum logic [1:0] {
        ADR_DATA = 2'd0,
        ADR_DP   = 2'd1,
        ADR_CTRL = 2'd2,
        ADR_RSVD = 2'd3
    } adr_e;

    // CTRL register bit positions
    localparam int CTRL_EN        = 0;
    localparam int CTRL_LZS       = 1;
    localparam int CTRL_BLANK_LSB = 8;

    // Segment pattern for a dark digit, before output polarity is applied
    localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex digit to gfedcba segment pattern, active-high.
module seven_seg_decoder (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    // Glyph table; b and d are lower-case so they differ from 8 and 0
    always_comb begin
        o_seg = 7'h00;
        case (i_hex)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// N-digit multiplexed seven-segment controller with a small bus register file.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          ADR_I,
    input  logic [31:0]         DAT_I,
    input  logic                STB,
    input  logic                WE,
    output logic [31:0]         DAT_O,
    output logic                ACK,
    output logic [7:0]          Segment,
    output logic [N_DIGITS-1:0] AN
);

    localparam int DW    = 4 * N_DIGITS;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam bit INV   = (ACTIVE_LOW != 0);

    logic [DW-1:0]       r_data;
    logic [N_DIGITS-1:0] r_dp;
    logic                r_en;
    logic                r_lzs;
    logic [N_DIGITS-1:0] r_blank;
    logic                r_ack;
    logic [31:0]         r_dat_o;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [N_DIGITS-1:0] r_an;
    logic [7:0]          r_seg;

    logic                w_xfer;
    logic                w_wr;
    logic [31:0]         w_rd;
    logic [IDX_W-1:0]    w_msd;
    logic [3:0]          w_nib;
    logic                w_dp_bit;
    logic                w_blank_bit;
    logic [N_DIGITS-1:0] w_an_hot;
    logic [6:0]          w_glyph;
    logic                w_lit;
    logic [N_DIGITS-1:0] w_an_on;
    logic [7:0]          w_seg_on;
    logic                w_unused;

    // A transfer is accepted on any STB cycle not already being acknowledged
    assign w_xfer   = STB & ~r_ack;
    assign w_wr     = w_xfer & WE;
    // Only part of DAT_I is stored, depending on N_DIGITS
    assign w_unused = ^DAT_I;

    // Readback mux; unimplemented bits and the reserved address read as zero
    always_comb begin
        w_rd = '0;
        case (adr_e'(ADR_I))
            ADR_DATA: w_rd[DW-1:0] = r_data;
            ADR_DP:   w_rd[N_DIGITS-1:0] = r_dp;
            ADR_CTRL: begin
                w_rd[CTRL_EN]                       = r_en;
                w_rd[CTRL_LZS]                      = r_lzs;
                w_rd[CTRL_BLANK_LSB +: N_DIGITS]    = r_blank;
            end
            ADR_RSVD: w_rd = '0;
            default:  w_rd = '0;
        endcase
    end

    // Bus handshake, registered read data and register writes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
            r_data  <= '0;
            r_dp    <= '0;
            r_en    <= 1'b1;
            r_lzs   <= 1'b0;
            r_blank <= '0;
        end else begin
            r_ack   <= w_xfer;
            r_dat_o <= w_xfer ? w_rd : '0;
            if (w_wr) begin
                case (adr_e'(ADR_I))
                    ADR_DATA: r_data <= DAT_I[DW-1:0];
                    ADR_DP:   r_dp   <= DAT_I[N_DIGITS-1:0];
                    ADR_CTRL: begin
                        r_en    <= DAT_I[CTRL_EN];
                        r_lzs   <= DAT_I[CTRL_LZS];
                        r_blank <= DAT_I[CTRL_BLANK_LSB +: N_DIGITS];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Scan timebase: each digit holds for SCAN_DIV cycles, runs even when disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Most significant nonzero nibble; stays 0 when DATA is all zero
    always_comb begin
        w_msd = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_data[4*k +: 4] != 4'h0) w_msd = IDX_W'(k);
        end
    end

    // Select the current digit's nibble, dp and blank bits, and its anode
    always_comb begin
        w_nib       = 4'h0;
        w_dp_bit    = 1'b0;
        w_blank_bit = 1'b0;
        w_an_hot    = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib       = r_data[4*k +: 4];
                w_dp_bit    = r_dp[k];
                w_blank_bit = r_blank[k];
                w_an_hot[k] = 1'b1;
            end
        end
    end

    seven_seg_decoder u_dec (
        .i_hex (w_nib),
        .o_seg (w_glyph)
    );

    assign w_lit    = r_en & ~w_blank_bit & ~(r_lzs & (r_idx > w_msd));
    assign w_an_on  = w_lit ? w_an_hot : '0;
    assign w_seg_on = w_lit ? {w_dp_bit, w_glyph} : SEG_OFF;

    // Output register; polarity is applied only here
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= {N_DIGITS{INV}};
            r_seg <= INV ? ~SEG_OFF : SEG_OFF;
        end else begin
            r_an  <= INV ? ~w_an_on  : w_an_on;
            r_seg <= INV ? ~w_seg_on : w_seg_on;
        end
    end

    assign ACK     = r_ack;
    assign DAT_O   = r_dat_o;
    assign AN      = r_an;
    assign Segment = r_seg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl (4 digits, SCAN_DIV=4, active-low).
module tb_seven_seg_scan_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  ADR_I;
    logic [31:0] DAT_I;
    logic        STB;
    logic        WE;
    logic [31:0] DAT_O;
    logic        ACK;
    logic [7:0]  Segment;
    logic [3:0]  AN;

    seven_seg_scan_ctrl #(
        .N_DIGITS   (4),
        .SCAN_DIV   (4),
        .ACTIVE_LOW (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ADR_I   (ADR_I),
        .DAT_I   (DAT_I),
        .STB     (STB),
        .WE      (WE),
        .DAT_O   (DAT_O),
        .ACK     (ACK),
        .Segment (Segment),
        .AN      (AN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ACK pops one expected response; DAT_O must be 0 otherwise
    always @(negedge clk) begin
        if (ACK) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ACK=1 with empty scoreboard at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.chk) check("rd_data", DAT_O, e.val);
            end
        end else begin
            check("dat_o_idle", DAT_O, 32'h0);
        end
    end

    task automatic xfer(input logic [1:0] adr, input bit we, input logic [31:0] dat,
                        input bit chk, input logic [31:0] exp);
        exp_t e;
        @(posedge clk); #1;
        check("ack_before", {31'b0, ACK}, 32'h0);
        ADR_I = adr; WE = we; DAT_I = dat; STB = 1'b1;
        e.chk = chk; e.val = exp;
        sb_q.push_back(e);
        @(posedge clk); #1;
        check("ack_rise", {31'b0, ACK}, 32'h1);
        STB = 1'b0; WE = 1'b0;
        @(posedge clk); #1;
        check("ack_fall", {31'b0, ACK}, 32'h0);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] dat);
        xfer(adr, 1'b1, dat, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [1:0] adr, input logic [31:0] exp);
        xfer(adr, 1'b0, 32'h0, 1'b1, exp);
    endtask

    // Observe one full scan period (16 cycles); exp_seg holds final pin values
    task automatic scan_chk(input string name, input logic [3:0] exp_lit,
                            input logic [3:0][7:0] exp_seg);
        logic [3:0] seen;
        logic [3:0] oh;
        int         off_cnt;
        bit         found;
        repeat (3) @(posedge clk);
        seen = '0;
        off_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (AN == 4'hF) begin
                off_cnt++;
                check({name, "_off_seg"}, {24'b0, Segment}, 32'hFF);
            end else begin
                found = 1'b0;
                for (int d = 0; d < 4; d++) begin
                    oh = 4'b0001 << d;
                    if (AN == ~oh) begin
                        found = 1'b1;
                        seen[d] = 1'b1;
                        check($sformatf("%s_seg%0d", name, d), {24'b0, Segment}, {24'b0, exp_seg[d]});
                    end
                end
                if (!found) check({name, "_an_onehot"}, {28'b0, AN}, 32'hF);
            end
        end
        check({name, "_lit_digits"}, {28'b0, seen}, {28'b0, exp_lit});
        check({name, "_off_cycles"}, 32'(off_cnt), 32'(4 * (4 - $countones(exp_lit))));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit hit;
        reset = 1'b1; STB = 1'b0; WE = 1'b0; ADR_I = 2'd0; DAT_I = 32'h0;

        // 1. reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   {31'b0, ACK}, 32'h0);
        check("rst_dat_o", DAT_O, 32'h0);
        check("rst_an",    {28'b0, AN}, 32'hF);
        check("rst_seg",   {24'b0, Segment}, 32'hFF);
        reset = 1'b0;
        rd(2'd2, 32'h0000_0001);

        // 2. data write, readback, full scan
        wr(2'd0, 32'h0000_1234);
        rd(2'd0, 32'h0000_1234);
        scan_chk("t2", 4'hF, {8'hF9, 8'hA4, 8'hB0, 8'h99});

        // 3. decimal points and DP width
        wr(2'd1, 32'h0000_0002);
        scan_chk("t3", 4'hF, {8'hF9, 8'hA4, 8'h30, 8'h99});
        wr(2'd1, 32'h0000_00FF);
        rd(2'd1, 32'h0000_000F);
        wr(2'd1, 32'h0);

        // 4. leading-zero suppression, DATA width
        wr(2'd0, 32'hDEAD_0050);
        rd(2'd0, 32'h0000_0050);
        wr(2'd2, 32'h0000_0003);
        scan_chk("t4a", 4'b0011, {8'hFF, 8'hFF, 8'h92, 8'hC0});
        wr(2'd0, 32'h0);
        scan_chk("t4b", 4'b0001, {8'hFF, 8'hFF, 8'hFF, 8'hC0});

        // 5. blank mask (upper mask bits ignored), disable, reserved address
        wr(2'd2, 32'h0000_F401);
        rd(2'd2, 32'h0000_0401);
        scan_chk("t5a", 4'b1011, {8'hC0, 8'hFF, 8'hC0, 8'hC0});
        wr(2'd2, 32'h0);
        scan_chk("t5b", 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hFF});
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, 32'h0);
        rd(2'd0, 32'h0);
        rd(2'd1, 32'h0);
        rd(2'd2, 32'h0);

        // 6a. held strobe: ACK alternates, one transfer per pulse
        @(posedge clk); #1;
        ADR_I = 2'd2; WE = 1'b0; STB = 1'b1;
        begin
            exp_t e;
            e.chk = 1'b1; e.val = 32'h0;
            sb_q.push_back(e);
            sb_q.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("hold_ack", {31'b0, ACK}, (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        STB = 1'b0;

        // 6b. reset while digit 2 is shown, with a write strobe in flight
        wr(2'd2, 32'h0000_0001);
        wr(2'd0, 32'h0000_1234);
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            if (AN == 4'hB) hit = 1'b1;
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_digit2: AN never showed digit 2 within 40 cycles");
        end
        reset = 1'b1;
        STB = 1'b1; WE = 1'b1; ADR_I = 2'd0; DAT_I = 32'h0000_FFFF;
        @(posedge clk); #1;
        check("midrst_an",  {28'b0, AN}, 32'hF);
        check("midrst_seg", {24'b0, Segment}, 32'hFF);
        check("midrst_ack", {31'b0, ACK}, 32'h0);
        reset = 1'b0; STB = 1'b0; WE = 1'b0;
        @(posedge clk); #1;
        check("postrst_an",  {28'b0, AN}, 32'hE);
        check("postrst_seg", {24'b0, Segment}, 32'hC0);
        rd(2'd0, 32'h0);
        rd(2'd2, 32'h0000_0001);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
